// File: rtl/route_sequencer.sv
// route_sequencer: walks a preloaded route of turn codes node by node,
// handing each code to the turn executor and waiting for it to finish.
// Ports: clk_50, rst (sync, active-high);
//   wr_en/wr_addr/wr_data load route entries (IDLE only);
//   route_len + go start a route;
//   sensor_l/m/r line sensors (1 = on line);
//   turn_done executor ack;
//   turn_cmd/turn_start drive the executor;
//   busy/route_done/fault/step_idx report progress.
module route_sequencer #(
  parameter int DEPTH    = 16,
  parameter int AW       = 4,
  parameter int NODE_DEB = 1000,
  parameter int TIMEOUT  = 50000000
) (
  input  logic          clk_50,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [2:0]    wr_data,
  input  logic [AW:0]   route_len,
  input  logic          go,
  input  logic          sensor_l,
  input  logic          sensor_m,
  input  logic          sensor_r,
  input  logic          turn_done,
  output logic [2:0]    turn_cmd,
  output logic          turn_start,
  output logic          busy,
  output logic          route_done,
  output logic          fault,
  output logic [AW:0]   step_idx
);

  localparam int DW = $clog2(NODE_DEB + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [DW-1:0] DEB_LAST =
    DW'(NODE_DEB - 1);
  localparam logic [TW-1:0] TO_LAST =
    TW'(TIMEOUT - 1);
  localparam logic [AW:0] LEN_MAX =
    (AW+1)'(DEPTH);

  localparam logic [2:0] C_STOP = 3'd0;
  localparam logic [2:0] C_FWD  = 3'd1;
  localparam logic [2:0] C_EXT  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FOLLOW,
    S_ISSUE,
    S_TURN,
    S_EXIT,
    S_FINISH,
    S_FAULT
  } state_t;

  state_t        r_state;
  state_t        w_next;

  logic [2:0]    r_mem [DEPTH];

  logic [DW-1:0] r_deb;
  logic [DW-1:0] w_deb;
  logic [TW-1:0] r_to;
  logic [AW:0]   r_len;
  logic [AW:0]   r_step;
  logic [AW:0]   w_step;

  logic [2:0]    r_turn_cmd;
  logic          r_turn_start;
  logic          r_busy;
  logic          r_route_done;
  logic          r_fault;

  logic [2:0]    w_cmd;
  logic          w_start;
  logic          w_busy;
  logic          w_done;
  logic          w_fault;

  logic          w_node;
  logic          w_go_ok;
  logic          w_to_hit;
  logic          w_timed;
  logic [2:0]    w_code;

  assign w_node   = sensor_l & sensor_m & sensor_r;
  assign w_go_ok  = go & (r_state == S_IDLE);
  assign w_to_hit = (r_to == TO_LAST);
  assign w_code   = r_mem[r_step[AW-1:0]];

  assign w_timed  = (r_state == S_FOLLOW) |
                    (r_state == S_TURN) |
                    (r_state == S_EXIT);

  assign turn_cmd   = r_turn_cmd;
  assign turn_start = r_turn_start;
  assign busy       = r_busy;
  assign route_done = r_route_done;
  assign fault      = r_fault;
  assign step_idx   = r_step;

  // Route memory has no reset: a route survives rst and can be replayed.
  always_ff @(posedge clk_50) begin
    if (wr_en && (r_state == S_IDLE)) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_deb        <= '0;
      r_to         <= '0;
      r_len        <= '0;
      r_step       <= '0;
      r_turn_cmd   <= C_STOP;
      r_turn_start <= 1'b0;
      r_busy       <= 1'b0;
      r_route_done <= 1'b0;
      r_fault      <= 1'b0;
    end else begin
      r_state <= w_next;
      r_deb   <= w_deb;
      r_step  <= w_step;

      if (w_go_ok) begin
        if (route_len > LEN_MAX) begin
          r_len <= LEN_MAX;
        end else begin
          r_len <= route_len;
        end
      end

      // Any state change restarts the wait budget.
      if (w_next != r_state) begin
        r_to <= '0;
      end else if (w_timed) begin
        r_to <= r_to + 1'b1;
      end else begin
        r_to <= '0;
      end

      r_turn_cmd   <= w_cmd;
      r_turn_start <= w_start;
      r_busy       <= w_busy;
      r_route_done <= w_done;
      r_fault      <= w_fault;
    end
  end

  // Completion events are tested before the timeout so that
  // a finish landing on the last budget cycle still wins.
  always_comb begin
    w_next = r_state;
    w_step = r_step;
    w_deb  = '0;
    unique case (r_state)
      S_IDLE: begin
        if (go) begin
          w_step = '0;
          if (route_len == '0) begin
            w_next = S_FINISH;
          end else begin
            w_next = S_FOLLOW;
          end
        end
      end
      S_FOLLOW: begin
        if (w_node && (r_deb == DEB_LAST)) begin
          w_next = S_ISSUE;
        end else begin
          if (w_node) begin
            w_deb = r_deb + 1'b1;
          end
          if (w_to_hit) begin
            w_next = S_FAULT;
          end
        end
      end
      S_ISSUE: begin
        if (w_code == C_STOP) begin
          w_next = S_FINISH;
        end else if (w_code > C_EXT) begin
          w_next = S_FAULT;
        end else begin
          w_next = S_TURN;
        end
      end
      S_TURN: begin
        if (turn_done) begin
          w_step = r_step + 1'b1;
          if (w_step == r_len) begin
            w_next = S_FINISH;
          end else begin
            w_next = S_EXIT;
          end
        end else if (w_to_hit) begin
          w_next = S_FAULT;
        end
      end
      S_EXIT: begin
        if (!w_node) begin
          w_next = S_FOLLOW;
        end else if (w_to_hit) begin
          w_next = S_FAULT;
        end
      end
      S_FINISH: w_next = S_IDLE;
      S_FAULT:  w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered,
  // so they line up with the state the block is entering.
  always_comb begin
    w_cmd   = C_STOP;
    w_start = 1'b0;
    w_busy  = 1'b0;
    w_done  = 1'b0;
    w_fault = r_fault;
    if (w_go_ok && (route_len != '0)) begin
      w_fault = 1'b0;
    end
    unique case (w_next)
      S_FOLLOW, S_ISSUE, S_EXIT: begin
        w_cmd  = C_FWD;
        w_busy = 1'b1;
      end
      S_TURN: begin
        // Code is captured on entry and held for the whole turn.
        if (r_state == S_TURN) begin
          w_cmd = r_turn_cmd;
        end else begin
          w_cmd = w_code;
        end
        w_start = 1'b1;
        w_busy  = 1'b1;
      end
      S_FINISH: w_done  = 1'b1;
      S_FAULT:  w_fault = 1'b1;
      default:  w_cmd   = C_STOP;
    endcase
  end

endmodule

// File: doc/route_sequencer.md
Name: route_sequencer

Overview:
- Sequences the line-follower's turn executor along a preloaded route of node-by-node turn commands.
- Follows the line, detects each node when all three sensors read the line, and issues the next turn code with a start strobe.
- Waits for the executor's done, clears the node, and repeats until the route ends.
- Sits between the route/path-planning logic and the turn executor, which feeds the motor control.

Parameters:
- DEPTH, 16: route memory entries.
- AW, 4: route address width; clog2(DEPTH).
- NODE_DEB, 1000: consecutive all-high sensor cycles that qualify a node.
- TIMEOUT, 50000000: maximum cycles allowed in any waiting state before fault (1 s at 50 MHz).

Ports:
- clk_50  in  1  system clock; single clock domain.
- rst  in  1  reset; synchronous, active-high.
- wr_en  in  1  route memory write strobe.
- wr_addr  in  AW  route memory write address.
- wr_data  in  3  turn code: 0 stop/end, 1 forward, 2 left, 3 right, 4 extreme.
- route_len  in  AW+1  number of valid entries, 0..DEPTH; sampled on accepted go.
- go  in  1  start-route pulse.
- sensor_l  in  1  left line sensor; 1 = on line.
- sensor_m  in  1  middle line sensor.
- sensor_r  in  1  right line sensor.
- turn_done  in  1  executor completion flag.
- turn_cmd  out  3  turn code to the executor.
- turn_start  out  1  executor enable.
- busy  out  1  route in progress.
- route_done  out  1  one-cycle pulse on route completion.
- fault  out  1  sticky error flag.
- step_idx  out  AW+1  index of the current or next route entry.

Behaviour:
- All outputs are registered.
- Reset values: turn_cmd=0, turn_start=0, busy=0, route_done=0, fault=0, step_idx=0; state IDLE; debounce and timeout counters cleared.
- Route memory is not cleared by rst.
- rst asserted mid-route: IDLE with reset output values on the next edge.
- Writes are accepted only in IDLE; wr_en while busy is ignored.
- IDLE: turn_cmd=stop.
  - go with route_len=0: route_done pulses in the next cycle; stay IDLE.
  - go with route_len>0: latch route_len, step_idx=0, fault=0, go to FOLLOW.
  - Latency: go at edge N gives busy=1 and turn_cmd=1 after edge N+1.
  - go while busy is ignored.
- FOLLOW: turn_cmd=forward, turn_start=0.
  - The debounce counter increments while l&m&r=1 and clears when any sensor is 0.
  - When the counter reaches NODE_DEB, go to ISSUE.
- ISSUE (1 cycle): read route[step_idx].
  - Code 0: go to FINISH.
  - Code 5..7: go to FAULT.
  - Otherwise: turn_cmd=code, turn_start=1, go to TURN.
- TURN: hold turn_cmd and turn_start=1 until turn_done=1.
  - Then turn_start=0 and step_idx++.
  - If the new step_idx equals the latched length, go to FINISH; else go to EXIT.
- EXIT: turn_cmd=forward.
  - Wait for any sensor=0 (node cleared), then go to FOLLOW with the debounce counter cleared.
- FINISH: turn_cmd=stop, route_done=1 for exactly one cycle, busy=0, go to IDLE.
- FAULT: turn_cmd=stop, turn_start=0, fault=1, busy=0, go to IDLE.
  - fault stays set until rst or the next accepted go.
- Timeout:
  - The counter clears on every state change.
  - It increments in FOLLOW, TURN and EXIT.
  - Reaching TIMEOUT goes to FAULT; a timeout in the same cycle as a completion event loses to the completion.
- busy=1 in FOLLOW, ISSUE, TURN and EXIT.
- turn_done outside TURN is ignored.
- A sensor glitch shorter than NODE_DEB never triggers ISSUE.

Test Plan (NODE_DEB=4, TIMEOUT=200, DEPTH=16):
- Load route {3,2,1}, route_len=3, go.
  - Required: turn_cmd=1 and busy=1 one cycle after go.
  - Hold sensors 111 for 4 cycles: turn_cmd=3, turn_start=1.
  - turn_done pulse: step_idx=1, EXIT.
  - Drop to 010: FOLLOW. Repeat for nodes 2 and 3.
  - After the third done: one-cycle route_done, busy=0, turn_cmd=0.
- Node debounce: in FOLLOW, apply 111 for 3 cycles, 010 for 1, then 111 for 3 -> no turn_start. A fourth consecutive 111 cycle -> turn_start=1.
- Route {2,0,...}, route_len=5: after the first turn completes and the next node is reached, code 0 -> route_done pulse with step_idx=1, no second turn_start.
- Timeout: in TURN, never assert turn_done -> after 200 cycles, fault=1, turn_cmd=0, busy=0. Next go -> fault=0, busy=1.
- Invalid code 6 at entry 0 -> FAULT at the first node; turn_start never asserted.
- Reset mid-TURN: assert rst for 1 cycle -> all outputs 0 next cycle. Memory retained: a new go replays the same route. wr_en during busy leaves the entry unchanged; route_len=0 with go gives a route_done pulse only.
